// File: rtl/cache_line_fill.sv
// Cache miss-side line filler: fetches a whole line from memory one byte per beat.
// Define CACHE_CRITICAL_WORD_FIRST_EN to fetch the missed byte first (wrapping order).
module cache_line_fill #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int LINE_BYTES = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic              clk_1,
   input  logic              rst,
   input  logic              miss_valid,
   output logic              miss_ready,
   input  logic [ADDR_W-1:0] miss_addr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              fill_we,
   output logic [ADDR_W-1:0] fill_addr,
   output logic [DATA_W-1:0] fill_data,
   output logic              fwd_valid,
   output logic [DATA_W-1:0] fwd_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // state | meaning
   // IDLE  | waiting for a miss, miss_ready high
   // REQ   | memory read of current beat outstanding, timeout running
   // FILL  | write latched beat into the cache, forward if it is the missed byte
   // DONE  | one-cycle completion pulse
   // ERR   | one-cycle abort pulse after timeout

   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [OFF_W-1:0] K_LAST   = OFF_W'(LINE_BYTES - 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      FILL = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } state_t;

   state_t                    state_q, state_d;
   logic [ADDR_W-OFF_W-1:0]   base_q;
   logic [OFF_W-1:0]          miss_off_q;
   logic [OFF_W-1:0]          k_q;
   logic [TMR_W-1:0]          tmr_q;
   logic [DATA_W-1:0]         fill_data_q;
   logic [OFF_W-1:0]          beat_off;
   logic [ADDR_W-1:0]         beat_addr;
   logic                      fwd_hit;
   logic                      tmr_expired;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
   assign beat_off = miss_off_q + k_q;
`else
   assign beat_off = k_q;
`endif

   assign beat_addr   = {base_q, beat_off};
   assign fwd_hit     = (beat_off == miss_off_q);
   // Down-counter reaching zero while still unacknowledged means TIMEOUT REQ cycles elapsed.
   assign tmr_expired = (TIMEOUT != 0) && (tmr_q == '0);

   always_ff @(posedge clk_1) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (miss_valid)        state_d = REQ;
         REQ: begin
            if (mem_ack)              state_d = FILL;
            else if (tmr_expired)     state_d = ERR;
         end
         FILL: state_d = (k_q == K_LAST) ? DONE : REQ;
         DONE: state_d = IDLE;
         ERR:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_1) begin
      if (rst) begin
         base_q      <= '0;
         miss_off_q  <= '0;
         k_q         <= '0;
         tmr_q       <= '0;
         fill_data_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (miss_valid) begin
                  base_q     <= miss_addr[ADDR_W-1:OFF_W];
                  miss_off_q <= miss_addr[OFF_W-1:0];
                  k_q        <= '0;
                  tmr_q      <= TMR_LOAD;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  fill_data_q <= mem_rdata;
               end else if (tmr_q != '0) begin
                  tmr_q <= tmr_q - TMR_W'(1);
               end
            end
            FILL: begin
               if (k_q != K_LAST) begin
                  k_q   <= k_q + OFF_W'(1);
                  tmr_q <= TMR_LOAD;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      miss_ready = (state_q == IDLE) && !rst;
      mem_req    = (state_q == REQ);
      mem_addr   = mem_req ? beat_addr : '0;
      fill_we    = (state_q == FILL);
      fill_addr  = fill_we ? beat_addr : '0;
      fill_data  = fill_data_q;
      fwd_valid  = fill_we && fwd_hit;
      fwd_data   = fwd_valid ? fill_data_q : '0;
      busy       = (state_q != IDLE);
      done       = (state_q == DONE);
      err        = (state_q == ERR);
   end

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed bench for cache_line_fill: reset, fills in both beat orders, timeout,
// slow memory with a competing miss, and reset in the middle of a fill.
module tb_cache_line_fill;

   logic        clk_1;
   logic        rst;
   logic        miss_valid;
   logic        miss_ready;
   logic [15:0] miss_addr;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        fill_we;
   logic [15:0] fill_addr;
   logic [7:0]  fill_data;
   logic        fwd_valid;
   logic [7:0]  fwd_data;
   logic        busy;
   logic        done;
   logic        err;

   int total = 0;
   int bad   = 0;

   cache_line_fill #(
      .ADDR_W(16), .DATA_W(8), .LINE_BYTES(4), .TIMEOUT(16)
   ) dut (
      .clk_1     (clk_1),
      .rst       (rst),
      .miss_valid(miss_valid),
      .miss_ready(miss_ready),
      .miss_addr (miss_addr),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .fill_we   (fill_we),
      .fill_addr (fill_addr),
      .fill_data (fill_data),
      .fwd_valid (fwd_valid),
      .fwd_data  (fwd_data),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk_1 = 1'b0;
   always #5 clk_1 = ~clk_1;

   function automatic logic [7:0] mem_model(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   assign mem_rdata = mem_model(mem_addr);

   function automatic logic [15:0] beat(input logic [15:0] a, input int k);
      logic [1:0] o;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
      o = a[1:0] + 2'(k);
`else
      o = 2'(k);
`endif
      return {a[15:2], o};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts at a negedge in IDLE, ends at the negedge of the IDLE cycle after done.
   task automatic do_fill(input logic [15:0] a, input int dly, input bit hold_valid);
      logic [15:0] ea;
      miss_addr  = a;
      miss_valid = 1'b1;
      mem_ack    = 1'b0;
      chk("ready_idle", miss_ready, 1);
      @(negedge clk_1);
      miss_addr  = ~a;
      miss_valid = hold_valid;
      for (int k = 0; k < 4; k++) begin
         ea = beat(a, k);
         for (int d = 0; d <= dly; d++) begin
            chk("mem_req", mem_req, 1);
            chk("mem_addr", mem_addr, ea);
            chk("ready_busy", miss_ready, 0);
            mem_ack = (d == dly);
            @(negedge clk_1);
         end
         chk("fill_we", fill_we, 1);
         chk("fill_addr", fill_addr, ea);
         chk("fill_data", fill_data, mem_model(ea));
         chk("req_drop", mem_req, 0);
         chk("fwd_valid", fwd_valid, (ea == a));
         if (ea == a) chk("fwd_data", fwd_data, mem_model(a));
         mem_ack = (dly == 0);
         @(negedge clk_1);
      end
      chk("done_pulse", done, 1);
      chk("done_no_err", err, 0);
      chk("done_no_we", fill_we, 0);
      @(negedge clk_1);
      chk("done_clear", done, 0);
      chk("busy_clear", busy, 0);
      chk("ready_back", miss_ready, 1);
   endtask

   initial begin
      // 1: reset with a pending miss
      rst        = 1'b1;
      miss_valid = 1'b1;
      miss_addr  = 16'h1236;
      mem_ack    = 1'b1;
      repeat (2) begin
         @(negedge clk_1);
         chk("rst_ready", miss_ready, 0);
         chk("rst_req", mem_req, 0);
         chk("rst_busy", busy, 0);
         chk("rst_we", fill_we, 0);
         chk("rst_fwd", fwd_valid, 0);
         chk("rst_done", done, 0);
         chk("rst_err", err, 0);
         chk("rst_maddr", mem_addr, 0);
         chk("rst_faddr", fill_addr, 0);
         chk("rst_fdata", fill_data, 0);
         chk("rst_fwdd", fwd_data, 0);
      end
      rst        = 1'b0;
      miss_valid = 1'b0;
      @(negedge clk_1);
      chk("post_rst_busy", busy, 0);

      // 2/3: miss 0x1236 with ack tied high; order depends on build
      do_fill(16'h1236, 0, 1'b0);

      // 4: memory never answers
      miss_addr  = 16'h4001;
      miss_valid = 1'b1;
      mem_ack    = 1'b0;
      chk("to_ready", miss_ready, 1);
      @(negedge clk_1);
      miss_valid = 1'b0;
      for (int c = 0; c < 16; c++) begin
         chk("to_req", mem_req, 1);
         chk("to_no_err", err, 0);
         @(negedge clk_1);
      end
      chk("to_err", err, 1);
      chk("to_req_low", mem_req, 0);
      chk("to_no_done", done, 0);
      chk("to_no_we", fill_we, 0);
      @(negedge clk_1);
      chk("to_err_clear", err, 0);
      chk("to_idle", busy, 0);

      // 5: slow memory, second miss held during the fill
      do_fill(16'h8CA1, 3, 1'b1);
      do_fill(16'h73FB, 0, 1'b0);

      // 6: reset in the middle of a fill
      miss_addr  = 16'hFFFE;
      miss_valid = 1'b1;
      mem_ack    = 1'b1;
      @(negedge clk_1);
      miss_valid = 1'b0;
      chk("r6_addr0", mem_addr, beat(16'hFFFE, 0));
      @(negedge clk_1);
      chk("r6_fill0", fill_addr, beat(16'hFFFE, 0));
      @(negedge clk_1);
      chk("r6_addr1", mem_addr, beat(16'hFFFE, 1));
      @(negedge clk_1);
      chk("r6_fill1", fill_addr, beat(16'hFFFE, 1));
      @(negedge clk_1);
      chk("r6_req2", mem_req, 1);
      rst = 1'b1;
      @(negedge clk_1);
      chk("r6_busy", busy, 0);
      chk("r6_req", mem_req, 0);
      chk("r6_ready_rst", miss_ready, 0);
      chk("r6_done", done, 0);
      chk("r6_err", err, 0);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk_1);
         chk("r6_quiet_done", done, 0);
         chk("r6_quiet_err", err, 0);
         chk("r6_quiet_we", fill_we, 0);
      end
      do_fill(16'h00F0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
